regfile_wb_queue: RTL

- Writer-side companion to the 32x64 register file.
- Accepts writeback requests (rd, data) from the datapath over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle onto the register file write port (RegWrite/rd/WriteData).
- Exposes combinational forwarding lookups so readers see pending, not-yet-committed values.

---
 rtl/regfile_wb_queue_pkg.sv | 14 +
 rtl/regfile_wb_queue_if.sv | 26 ++
 rtl/regfile_wb_queue_store.sv | 86 ++++++++
 rtl/regfile_wb_queue.sv | 74 +++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and widths for the register-file writeback queue.
package regfile_wb_queue_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned AW       = $clog2(NUM_REGS);

    // One pending register-file write.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Writeback request handshake plus the register-file write port.
interface regfile_wb_queue_if;
    import regfile_wb_queue_pkg::*;

    logic            wb_valid;
    logic            wb_ready;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            rf_RegWrite;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_WriteData;

    // Datapath / register-file side.
    modport master (
        output wb_valid, wb_rd, wb_data,
        input  wb_ready, rf_RegWrite, rf_rd, rf_WriteData
    );

    // Queue side.
    modport slave (
        input  wb_valid, wb_rd, wb_data,
        output wb_ready, rf_RegWrite, rf_rd, rf_WriteData
    );

endinterface

// File: rtl/regfile_wb_queue_store.sv
// In-order entry storage with valid bits, pointers, occupancy count and
// youngest-match forwarding search for two read addresses.
module regfile_wb_queue_store
    import regfile_wb_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  wb_req_t         i_push_req,
    input  logic            i_pop,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rs2,
    output wb_req_t         o_head,
    output logic [CW-1:0]   o_count,
    output logic            o_fwd1_hit,
    output logic [XLEN-1:0] o_fwd1_data,
    output logic            o_fwd2_hit,
    output logic [XLEN-1:0] o_fwd2_data
);

    wb_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    // Pointer, valid-bit and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_push_req;
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_idx       = '0;
        o_fwd1_hit  = 1'b0;
        o_fwd1_data = '0;
        o_fwd2_hit  = 1'b0;
        o_fwd2_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] && (i_rs1 != '0) && (r_mem[w_idx].rd == i_rs1)) begin
                o_fwd1_hit  = 1'b1;
                o_fwd1_data = r_mem[w_idx].data;
            end
            if (r_valid[w_idx] && (i_rs2 != '0) && (r_mem[w_idx].rd == i_rs2)) begin
                o_fwd2_hit  = 1'b1;
                o_fwd2_data = r_mem[w_idx].data;
            end
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue: accepts (rd, data) requests, buffers them in order and
// drains one per cycle into the register file, forwarding pending values.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_queue_if.slave    wb_if,
    input  logic                 i_hold,
    input  logic [AW-1:0]        i_rs1,
    input  logic [AW-1:0]        i_rs2,
    output logic                 o_fwd1_hit,
    output logic [XLEN-1:0]      o_fwd1_data,
    output logic                 o_fwd2_hit,
    output logic [XLEN-1:0]      o_fwd2_data,
    output logic [CW-1:0]        o_count,
    output logic                 o_empty
);

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    wb_req_t       w_push_req;
    wb_req_t       w_head;
    logic [CW-1:0] w_count;

    // Handshake and drain decisions; ready looks only at stored occupancy
    // (gated by reset so nothing is offered while held in reset).
    always_comb begin
        w_ready         = rst_n && (w_count < CW'(DEPTH));
        w_pop           = (w_count != '0) && !i_hold;
        // Writes to x0 complete the handshake but are never queued.
        w_push          = wb_if.wb_valid && w_ready && (wb_if.wb_rd != '0);
        w_push_req.rd   = wb_if.wb_rd;
        w_push_req.data = wb_if.wb_data;
    end

    // Register-file port shows the head entry only while committing.
    always_comb begin
        wb_if.rf_RegWrite  = w_pop;
        wb_if.rf_rd        = '0;
        wb_if.rf_WriteData = '0;
        if (w_pop) begin
            wb_if.rf_rd        = w_head.rd;
            wb_if.rf_WriteData = w_head.data;
        end
    end

    assign wb_if.wb_ready = w_ready;
    assign o_count        = w_count;
    assign o_empty        = (w_count == '0);

    regfile_wb_queue_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_req  (w_push_req),
        .i_pop       (w_pop),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_fwd1_hit  (o_fwd1_hit),
        .o_fwd1_data (o_fwd1_data),
        .o_fwd2_hit  (o_fwd2_hit),
        .o_fwd2_data (o_fwd2_data)
    );

endmodule
